dmem_cache: RTL and testbench
=============================

// Module: dmem_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache that answers the CPU MEM stage's load/store requests.
//  It is the responder end of the CPU data-memory interface.
//  Backing-store side is a line-wide, single-outstanding request/response port to the main memory model.
//  The CPU holds its MEM stage until resp_valid is seen; one request is in flight at a time.
// PARAMETERS
//  LINE_WORDS  4   32-bit words per line (power of 2, >=2)
//  NUM_SETS    16  lines in the cache (power of 2)
//  ADDR_W      32  byte-address width
// PORTS
//  clk             in   1               clock; all state updates on posedge
//  reset           in   1               synchronous, active-high
//  req_valid       in   1               CPU request present
//  req_ready       out  1               cache can accept a request (IDLE only)
//  req_write       in   1               1 = store, 0 = load
//  req_addr        in   ADDR_W          byte address; bits [1:0] ignored
//  req_wdata       in   32              store data
//  resp_valid      out  1               one-cycle pulse: access complete
//  resp_rdata      out  32              load data, valid with resp_valid (0 for stores)
//  mem_req_valid   out  1               backing-store request
//  mem_req_ready   in   1               backing store accepts request
//  mem_req_write   out  1               1 = line writeback, 0 = line fill
//  mem_req_addr    out  ADDR_W          line-aligned byte address
//  mem_req_wdata   out  32*LINE_WORDS   writeback line, word0 in LSBs
//  mem_resp_valid  in   1               fill data ready / writeback acknowledged
//  mem_resp_rdata  in   32*LINE_WORDS   fill line
//  hit_count       out  32              lookups that hit on first probe (wraps)
//  miss_count      out  32              lookups that missed (wraps)
// BEHAVIOUR
//  Address split: word offset = [2 +: log2(LINE_WORDS)], index = next log2(NUM_SETS) bits, tag = remaining upper bits.
//   Defaults: [3:2], [7:4], [31:8].
//  Reset:
//   - state IDLE; all valid and dirty bits cleared; counters 0.
//   - req_ready=1; resp_valid=0; resp_rdata=0; mem_req_valid=0; mem_req_addr=0; mem_req_wdata=0.
//   - Any in-flight memory transaction is abandoned; the bench resets the memory model in the same cycle.
//   - Data array contents are don't-care after reset.
//  FSM states: IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT.
//  IDLE: req_ready=1. When req_valid, the cache latches write/addr/wdata and moves to LOOKUP.
//  LOOKUP: hit = valid[idx] && tag[idx]==tag.
//   - Hit: resp_valid=1 this cycle. Load: resp_rdata = word. Store: word written, dirty[idx]=1. Go to IDLE.
//   - First-probe hit increments hit_count.
//   - Miss: increments miss_count. Go to WB_REQ if valid && dirty, else FILL_REQ.
//   - Hit latency: request accepted at edge T, resp_valid high in cycle T+1. Next accept no earlier than T+2.
//  WB_REQ: mem_req_valid=1, write=1, addr = {old tag, idx, 0}, wdata = line.
//   - All mem_req_* held stable until mem_req_ready; then go to WB_WAIT.
//  WB_WAIT: on mem_resp_valid, dirty[idx]=0; go to FILL_REQ.
//  FILL_REQ: mem_req_valid=1, write=0, addr = {new tag, idx, 0}. Held until mem_req_ready; then go to FILL_WAIT.
//  FILL_WAIT: on mem_resp_valid, write the line, tag, valid=1, dirty=0; go to LOOKUP.
//   - The re-probe hits and is not counted again (a re-probe flag suppresses the counters).
//  Boundary cases:
//   - mem_req_ready in the same cycle mem_req_valid rises is legal: one-cycle request.
//   - mem_resp_valid outside WB_WAIT/FILL_WAIT is ignored.
//   - mem_resp_valid in the cycle after the handshake is legal.
//   - req_valid while not IDLE is ignored; the CPU must hold it.
//   - Index 0 and index NUM_SETS-1 behave identically; no wrap logic beyond counter wrap at 2^32.
//   - Reset asserted in any state wins over every other event in that cycle.
// STRUCTURE
//  Shared package cache_pkg: state encoding and width constants derived from LINE_WORDS/NUM_SETS/ADDR_W
//   (OFF_W, IDX_W, TAG_W), plus line-address build helpers.
//  Sub-module dcache_array: valid/dirty/tag/data storage.
//   - Async read by index.
//   - Sync word write, line fill, and dirty clear.
//   - Reset clears valid/dirty only.
//  Top level holds the FSM, request latch, counters and port muxing.
// TESTING
//  1. Cold load:
//   - Stimulus: reset, then load 0x100, memory line = {4,3,2,1}.
//   - Response: one FILL (addr 0x100), resp_rdata=1; miss_count=1, hit_count=0.
//  2. Hit after fill:
//   - Stimulus: load 0x10C.
//   - Response: resp_valid exactly 1 cycle after accept, rdata=4; hit_count=1; no mem_req_valid.
//  3. Store then evict:
//   - Stimulus: store 0xAA to 0x104, then load 0x204 (same index, new tag).
//   - Response: WB_REQ addr 0x100 with wdata word1=0xAA, then FILL addr 0x200; dirty cleared.
//  4. Backpressure:
//   - Stimulus: mem_req_ready low for 5 cycles, resp delay 3.
//   - Response: mem_req_* stable throughout; exactly one request per line.
//  5. Reset mid-fill:
//   - Stimulus: assert reset in FILL_WAIT.
//   - Response: next cycle IDLE, req_ready=1, counters 0; the prior address misses again.
//  6. Counter/parity sweep:
//   - Stimulus: 1000 random loads/stores vs a flat reference memory.
//   - Response: all rdata match; hit_count+miss_count = accepted requests.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the MEM-stage data cache: FSM encoding, default geometry,
// derived address-field widths and a line-address helper.
package cache_pkg;

    localparam int WORD_W         = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_SETS   = 16;
    localparam int DEF_ADDR_W     = 32;

    localparam int OFF_W = $clog2(DEF_LINE_WORDS);
    localparam int IDX_W = $clog2(DEF_NUM_SETS);
    localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_REQ,
        S_WB_WAIT,
        S_FILL_REQ,
        S_FILL_WAIT
    } state_t;

    // Line-aligned byte address for the default geometry.
    function automatic logic [DEF_ADDR_W-1:0] line_addr(logic [TAG_W-1:0] tag,
                                                        logic [IDX_W-1:0] idx);
        return {tag, idx, {(OFF_W + 2){1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage for the direct-mapped cache. Reads are asynchronous by index;
// word writes, line fills and dirty clears land on the clock edge. Reset clears valid/dirty only.
module dcache_array #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 16,
    parameter int TAG_W      = 24
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [$clog2(NUM_SETS)-1:0]       idx,
    output logic                              rd_valid,
    output logic                              rd_dirty,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic [32*LINE_WORDS-1:0]          rd_line,
    input  logic                              wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0]     wr_off,
    input  logic [31:0]                       wr_data,
    input  logic                              fill_en,
    input  logic [TAG_W-1:0]                  fill_tag,
    input  logic [32*LINE_WORDS-1:0]          fill_line,
    input  logic                              clean_en
);

    logic [NUM_SETS-1:0]       valid;
    logic [NUM_SETS-1:0]       dirty;
    logic [TAG_W-1:0]          tags [NUM_SETS];
    logic [32*LINE_WORDS-1:0]  data [NUM_SETS];

    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];
    assign rd_tag   = tags[idx];
    assign rd_line  = data[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_en) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (wr_en) begin
            dirty[idx] <= 1'b1;
        end else if (clean_en) begin
            dirty[idx] <= 1'b0;
        end
    end

    // Tag and data carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_en) begin
                data[idx] <= fill_line;
                tags[idx] <= fill_tag;
            end else if (wr_en) begin
                data[idx][32*wr_off +: 32] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/dmem_cache.sv
// Direct-mapped write-back write-allocate data cache for the CPU MEM stage; hits respond the
// cycle after accept, misses write back a dirty victim then fill over a single-outstanding line port.
module dmem_cache
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       resp_valid,
    output logic [31:0]                resp_rdata,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_write,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [32*LINE_WORDS-1:0]   mem_req_wdata,
    input  logic                       mem_resp_valid,
    input  logic [32*LINE_WORDS-1:0]   mem_resp_rdata,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
);

    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_SETS);
    localparam int TB = ADDR_W - IB - OB - 2;

    state_t state, state_nxt;

    logic                 lat_write;
    logic [ADDR_W-1:2]    lat_addr;
    logic [31:0]          lat_wdata;
    logic                 reprobe;

    logic [IB-1:0]        idx;
    logic [OB-1:0]        off;
    logic [TB-1:0]        tag;

    logic                 rd_valid, rd_dirty;
    logic [TB-1:0]        rd_tag;
    logic [32*LINE_WORDS-1:0] rd_line;
    logic [31:0]          rd_word;
    logic                 hit;

    logic                 wr_en, fill_en, clean_en;

    // Byte-lane bits of the address have no meaning for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[1:0]};

    assign idx     = lat_addr[2+OB +: IB];
    assign off     = lat_addr[2 +: OB];
    assign tag     = lat_addr[ADDR_W-1 -: TB];
    assign rd_word = rd_line[32*off +: 32];
    assign hit     = rd_valid && (rd_tag == tag);

    dcache_array #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_SETS   (NUM_SETS),
        .TAG_W      (TB)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .idx       (idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_off    (off),
        .wr_data   (lat_wdata),
        .fill_en   (fill_en),
        .fill_tag  (tag),
        .fill_line (mem_resp_rdata),
        .clean_en  (clean_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            reprobe    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_valid) begin
                lat_write <= req_write;
                lat_addr  <= req_addr[ADDR_W-1:2];
                lat_wdata <= req_wdata;
                reprobe   <= 1'b0;
            end
            // The post-fill probe is a guaranteed hit and must not count twice.
            if (state == S_LOOKUP && !reprobe) begin
                if (hit) hit_count  <= hit_count + 32'd1;
                else     miss_count <= miss_count + 32'd1;
            end
            if (state == S_FILL_WAIT && mem_resp_valid) reprobe <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        wr_en         = 1'b0;
        fill_en       = 1'b0;
        clean_en      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_rdata = lat_write ? 32'd0 : rd_word;
                    wr_en      = lat_write;
                    state_nxt  = S_IDLE;
                end else if (rd_valid && rd_dirty) begin
                    state_nxt = S_WB_REQ;
                end else begin
                    state_nxt = S_FILL_REQ;
                end
            end
            S_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {rd_tag, idx, {(OB + 2){1'b0}}};
                mem_req_wdata = rd_line;
                if (mem_req_ready) state_nxt = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                if (mem_resp_valid) begin
                    clean_en  = 1'b1;
                    state_nxt = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag, idx, {(OB + 2){1'b0}}};
                if (mem_req_ready) state_nxt = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (mem_resp_valid) begin
                    fill_en   = 1'b1;
                    state_nxt = S_LOOKUP;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_cache.sv
// Scoreboard bench for dmem_cache: directed cache scenarios plus a random sweep against a flat
// reference memory, with a backing-store model that has programmable ready/response delays.
module tb_dmem_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready, req_write;
    logic [31:0]  req_addr, req_wdata;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_rdata;
    logic [31:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    dmem_cache dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accepted = 0;
    int acc_cyc = 0;
    int resp_seen = 0;
    int resp_cyc = 0;
    logic [31:0] expq [$];

    logic [31:0] bmem [logic [31:0]];
    logic [31:0] refm [logic [31:0]];

    int           rdy_dly = 0, rsp_dly = 0;
    bit           m_busy = 1'b0;
    int           m_cnt = 0, m_rcnt = 0;
    logic         p_write;
    logic [31:0]  p_addr;
    logic         s_write;
    logic [31:0]  s_addr;
    logic [127:0] s_wdata;
    int           wb_cnt = 0, fill_cnt = 0, stab_err = 0;
    logic [31:0]  last_wb_addr = '0, last_fill_addr = '0;
    logic [127:0] last_wb_data = '0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] brd(logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rrd(logic [31:0] a);
        return refm.exists(a) ? refm[a] : dflt(a);
    endfunction

    function automatic logic [127:0] bline(logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = brd(a + 32'(4*i));
        return l;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Backing-store model, driven on the falling edge.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (reset) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else if (m_busy) begin
                if (m_rcnt >= rsp_dly) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = p_write ? 128'd0 : bline(p_addr);
                    m_busy = 1'b0;
                end else begin
                    m_rcnt++;
                end
            end else if (mem_req_valid) begin
                if (m_cnt == 0) begin
                    s_write = mem_req_write;
                    s_addr  = mem_req_addr;
                    s_wdata = mem_req_wdata;
                end else if (s_write !== mem_req_write || s_addr !== mem_req_addr ||
                             s_wdata !== mem_req_wdata) begin
                    stab_err++;
                end
                if (m_cnt >= rdy_dly) begin
                    mem_req_ready = 1'b1;
                    m_busy  = 1'b1;
                    m_rcnt  = 0;
                    m_cnt   = 0;
                    p_write = mem_req_write;
                    p_addr  = mem_req_addr;
                    if (mem_req_write) begin
                        wb_cnt++;
                        last_wb_addr = mem_req_addr;
                        last_wb_data = mem_req_wdata;
                        for (int i = 0; i < 4; i++)
                            bmem[mem_req_addr + 32'(4*i)] = mem_req_wdata[32*i +: 32];
                    end else begin
                        fill_cnt++;
                        last_fill_addr = mem_req_addr;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Response monitor: every resp_valid pulse consumes one scoreboard entry.
    initial forever begin
        @(negedge clk);
        if (resp_valid === 1'b1) begin
            resp_seen++;
            resp_cyc = cyc;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata %0h with nothing expected", resp_rdata);
            end else begin
                chk("resp_rdata", resp_rdata, expq.pop_front());
            end
        end
    end

    task automatic issue(logic w, logic [31:0] a, logic [31:0] d);
        int s0;
        int n;
        s0 = resp_seen;
        expq.push_back(w ? 32'd0 : rrd(a));
        if (w) refm[a] = d;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        accepted++;
        req_valid = 1'b0;
        n = 0;
        while (resp_seen == s0) begin
            @(posedge clk);
            n++;
            if (n > 300) begin
                chk("resp_timeout", 1, 0);
                break;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        expq.delete();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        accepted = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int f0, w0, n;
    logic [127:0] exp_wb;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            bmem[32'h100 + 32'(4*i)] = 32'(i + 1);
            refm[32'h100 + 32'(4*i)] = 32'(i + 1);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        chk("rst_mem_req_wdata", mem_req_wdata, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        @(posedge clk);
        #1;

        // Cold load
        f0 = fill_cnt;
        issue(1'b0, 32'h100, 32'h0);
        chk("cold_fill_cnt", fill_cnt - f0, 1);
        chk("cold_fill_addr", last_fill_addr, 32'h100);
        chk("cold_miss", miss_count, 1);
        chk("cold_hit", hit_count, 0);

        // Hit after fill
        n = wb_cnt + fill_cnt;
        issue(1'b0, 32'h10C, 32'h0);
        chk("hit_latency", resp_cyc, acc_cyc);
        chk("hit_no_mem_req", wb_cnt + fill_cnt, n);
        chk("hit_count_1", hit_count, 1);

        // Top index behaves like index 0
        issue(1'b0, 32'h0FC, 32'h0);
        chk("idx15_fill_addr", last_fill_addr, 32'h0F0);
        issue(1'b0, 32'h0FC, 32'h0);
        chk("idx15_hit", hit_count, 2);
        chk("idx15_miss", miss_count, 2);

        // Store then evict
        issue(1'b1, 32'h104, 32'hAA);
        w0 = wb_cnt;
        f0 = fill_cnt;
        issue(1'b0, 32'h204, 32'h0);
        exp_wb = {32'd4, 32'd3, 32'hAA, 32'd1};
        chk("evict_wb_cnt", wb_cnt - w0, 1);
        chk("evict_wb_addr", last_wb_addr, 32'h100);
        chk("evict_wb_data", last_wb_data, exp_wb);
        chk("evict_fill_addr", last_fill_addr, 32'h200);
        chk("evict_fill_cnt", fill_cnt - f0, 1);
        w0 = wb_cnt;
        issue(1'b0, 32'h104, 32'h0);
        chk("clean_evict_no_wb", wb_cnt - w0, 0);
        chk("evict_hit", hit_count, 3);
        chk("evict_miss", miss_count, 4);

        // Backpressure on both request and response
        rdy_dly = 5;
        rsp_dly = 3;
        issue(1'b1, 32'h108, 32'h55);
        w0 = wb_cnt;
        f0 = fill_cnt;
        issue(1'b0, 32'h300, 32'h0);
        chk("bp_wb_once", wb_cnt - w0, 1);
        chk("bp_fill_once", fill_cnt - f0, 1);
        chk("bp_wb_addr", last_wb_addr, 32'h100);
        chk("bp_stable", stab_err, 0);
        chk("bp_hit", hit_count, 4);
        chk("bp_miss", miss_count, 5);

        // Reset while a fill is outstanding
        rdy_dly = 0;
        rsp_dly = 8;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h400;
        req_wdata = '0;
        n = 0;
        while (!(m_busy && !p_write)) begin
            @(posedge clk);
            n++;
            if (n > 100) begin
                chk("fillwait_timeout", 1, 0);
                break;
            end
        end
        #1;
        do_reset();
        @(negedge clk);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_hit", hit_count, 0);
        chk("midrst_miss", miss_count, 0);
        chk("midrst_mem_req_valid", mem_req_valid, 0);
        @(posedge clk);
        #1;
        rsp_dly = 0;
        f0 = fill_cnt;
        issue(1'b0, 32'h104, 32'h0);
        chk("post_rst_refill", fill_cnt - f0, 1);
        chk("post_rst_miss", miss_count, 1);
        chk("post_rst_hit", hit_count, 0);

        // Random sweep against the flat reference
        for (int i = 0; i < 1000; i++) begin
            rdy_dly = $urandom_range(0, 2);
            rsp_dly = $urandom_range(0, 2);
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)) << 2, $urandom);
        end
        chk("sweep_count_sum", hit_count + miss_count, 32'(accepted));
        chk("sweep_stable", stab_err, 0);
        chk("sweep_queue_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
